spd_slew: RTL
=============

// Module: spd_slew
// PURPOSE
//  Rate limiter between the PID heading controller and the motor drive. It takes raw signed
//  left/right speed targets and emits slewed lft_spd/rght_spd (signed 11-bit) to MtrDrv.
//  It bounds wheel acceleration, ramps to zero when not moving, and forces a zero-speed dwell
//  before any direction reversal, protecting H-bridge and gearbox.
// PARAMETERS
//  STEP      8     max |change| of an output per tick (LSBs, 1..1023)
//  TICK_DIV  1024  clk cycles per slew tick (>=2)
//  DWELL     4     ticks held at zero before reversing direction (>=1)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  tgt_lft   in   11  signed left target speed from PID
//  tgt_rght  in   11  signed right target speed from PID
//  moving    in   1   1 = track targets; 0 = effective target forced to 0
//  lft_spd   out  11  signed slewed left speed (registered) -> MtrDrv
//  rght_spd  out  11  signed slewed right speed (registered) -> MtrDrv
//  settled   out  1   both channels in RUN and output == effective target (registered)
// BEHAVIOUR
//  - One clock domain; reset is asynchronous active-low. Reset: lft_spd=rght_spd=0,
//    settled=0, prescaler=0, both channel FSMs=RUN, dwell counters=0.
//  - Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 for one clk when count==TICK_DIV-1.
//    First tick after reset is at clk edge TICK_DIV.
//  - Effective target eff = moving ? clamp(tgt,-1023,+1023) : 0. -1024 is never emitted.
//  - eff is sampled only on tick. Outputs update on the tick edge (1-clk latency from tick).
//  - Arithmetic: diff = eff - spd in 12-bit signed. step = min(STEP,|diff|), toward eff.
//    Results stay within [-1023,+1023]; no wrap is possible.
//  - Per-channel FSM, evaluated only on tick. Between ticks: state and outputs hold.
//    RUN:     spd!=0 && eff!=0 && sign(eff)!=sign(spd) -> TO_ZERO; step spd toward 0.
//             Otherwise step spd toward eff and stay in RUN. spd==0 never starts a reversal.
//    TO_ZERO: eff==0 or sign(eff)==sign(spd) -> RUN; step toward eff on this same tick.
//             Otherwise step toward 0. When the new spd==0 -> DWELL, dwell_cnt=0.
//    DWELL:   spd held at 0, eff ignored. dwell_cnt++ each tick.
//             When dwell_cnt==DWELL-1 -> RUN; the first nonzero step is on the next tick.
//  - Channels are independent. A left reversal never stalls the right channel.
//  - settled = (both FSM==RUN) && lft_spd==eff_l && rght_spd==eff_r, with eff taken from
//    the current inputs. It is recomputed every clk and registered.
//  - moving falling mid-ramp: both channels ramp to 0 at STEP/tick. No dwell occurs,
//    because eff==0 is not a reversal.
//  - Reset mid-operation: outputs go to 0 immediately (async). There is no ramp-down on reset.
// STRUCTURE
//  - Shared package mtr_pkg holds: typedef logic signed [10:0] spd_t; SPD_MAX=11'sd1023;
//    typedef enum logic [1:0] {RUN, TO_ZERO, DWELL} slew_st_t.
//  - Sub-module spd_slew_chnl: one channel FSM, dwell counter, clamp/step datapath. It takes
//    clk, rst_n, tick, moving, tgt and outputs spd and in_run. It is instantiated twice.
//  - Top level holds the prescaler, the two instances and the settled register.
// TESTING (STEP=8, TICK_DIV=4, DWELL=4 unless stated)
//  1 Reset, moving=1, tgt_lft=100 -> lft_spd 0,8,16..96,100 on successive ticks (13 ticks).
//    settled=1 after the last step if tgt_rght=0.
//  2 lft_spd=+40 settled, tgt_lft=-40 -> 32,24,16,8,0, then 4 ticks at 0, then -8..-40.
//    No sample may show a sign flip without an intervening 0.
//  3 In TO_ZERO at +16, tgt_lft back to +50 -> RUN on that tick: 24,32..50, no dwell.
//  4 tgt_lft=1023, tgt_rght=-1024, STEP=1023 -> first tick gives 1023 and -1023 (clamped).
//    Never -1024.
//  5 Both at +200, moving 1->0 -> both ramp 192..0 at 8/tick with no dwell. settled=1 at 0.
//    moving=1 with tgt=+200 -> immediate ramp up.
//  6 Assert rst_n=0 mid-ramp between clk edges -> outputs 0 immediately.
//    After release, first change occurs exactly TICK_DIV clks later.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared motor-path types: signed wheel speed, its legal magnitude, the slew channel
// states, and the effective-target helper used by both the channel and the top level.
package mtr_pkg;

   typedef logic signed [10:0] spd_t;

   localparam spd_t SPD_MAX = 11'sd1023;

   typedef enum logic [1:0] {RUN, TO_ZERO, DWELL} slew_st_t;

   // Effective target: zero when not moving, otherwise the target with -1024 folded to
   // -1023 so the output range is symmetric.
   function automatic spd_t eff_tgt(input spd_t tgt, input logic moving);
      if (!moving) begin
         return '0;
      end
      if (tgt < -SPD_MAX) begin
         return -SPD_MAX;
      end
      return tgt;
   endfunction

endpackage

// File: rtl/spd_slew_if.sv
// Speed-target / slewed-speed bundle between the PID controller, the slew limiter and
// the motor drive.
//   tgt_lft, tgt_rght : signed raw targets from the PID
//   moving            : 1 = track targets, 0 = ramp to zero
//   lft_spd, rght_spd : signed slewed speeds to the motor drive
//   settled           : both channels running and at their effective targets
// master drives targets (controller side); slave is the slew limiter.
interface spd_slew_if;
   import mtr_pkg::*;

   spd_t tgt_lft;
   spd_t tgt_rght;
   logic moving;
   spd_t lft_spd;
   spd_t rght_spd;
   logic settled;

   modport master (
      output tgt_lft,
      output tgt_rght,
      output moving,
      input  lft_spd,
      input  rght_spd,
      input  settled
   );

   modport slave (
      input  tgt_lft,
      input  tgt_rght,
      input  moving,
      output lft_spd,
      output rght_spd,
      output settled
   );

endinterface

// File: rtl/spd_slew_chnl.sv
// One wheel channel of the slew limiter: clamp/step datapath plus the reversal FSM and
// its dwell counter. Everything advances only on tick; between ticks it holds.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-clk slew strobe from the shared prescaler
//   moving     : 0 forces the effective target to zero
//   tgt        : signed raw target
//   spd        : signed slewed speed (registered)
//   in_run     : channel FSM is in RUN
module spd_slew_chnl
   import mtr_pkg::*;
#(
   parameter int unsigned STEP        = 8,
   parameter int unsigned DWELL_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic moving,
   input  spd_t tgt,
   output spd_t spd,
   output logic in_run
);

   localparam int unsigned CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [CW-1:0]       DWELL_LAST = CW'(DWELL_TICKS - 1);
   localparam logic signed [11:0]  STEP_W     = 12'(STEP);
   localparam spd_t                STEP_V     = 11'(STEP);

   slew_st_t      st_q, st_d;
   spd_t          spd_q, spd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   spd_t          eff;
   logic          reversing;

   // Move cur by at most STEP toward dst; the difference is taken in 12 bits so that
   // +1023 - -1023 cannot wrap.
   function automatic spd_t step_toward(input spd_t cur, input spd_t dst);
      logic signed [11:0] diff;
      logic signed [11:0] mag;
      diff = {dst[10], dst} - {cur[10], cur};
      mag  = (diff < 0) ? -diff : diff;
      if (mag <= STEP_W) begin
         return dst;
      end
      return (diff < 0) ? (cur - STEP_V) : (cur + STEP_V);
   endfunction

   always_comb begin
      eff       = eff_tgt(tgt, moving);
      // A zero speed or zero target never counts as a reversal.
      reversing = (spd_q != '0) && (eff != '0) && (eff[10] != spd_q[10]);
      st_d      = st_q;
      spd_d     = spd_q;
      cnt_d     = cnt_q;
      if (tick) begin
         unique case (st_q)
            RUN: begin
               if (reversing) begin
                  spd_d = step_toward(spd_q, '0);
                  // Landing on zero in this very step goes straight to the dwell, otherwise
                  // TO_ZERO would see spd==0 next tick and skip it.
                  st_d  = (spd_d == '0) ? mtr_pkg::DWELL : TO_ZERO;
                  cnt_d = '0;
               end else begin
                  spd_d = step_toward(spd_q, eff);
               end
            end
            TO_ZERO: begin
               if (!reversing) begin
                  st_d  = RUN;
                  spd_d = step_toward(spd_q, eff);
               end else begin
                  spd_d = step_toward(spd_q, '0);
                  if (spd_d == '0) begin
                     st_d  = mtr_pkg::DWELL;
                     cnt_d = '0;
                  end
               end
            end
            mtr_pkg::DWELL: begin
               spd_d = '0;
               cnt_d = CW'(cnt_q + 1'b1);
               if (cnt_q == DWELL_LAST) begin
                  st_d  = RUN;
                  cnt_d = '0;
               end
            end
            default: begin
               st_d  = RUN;
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= RUN;
         spd_q <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         spd_q <= spd_d;
         cnt_q <= cnt_d;
      end
   end

   assign spd    = spd_q;
   assign in_run = (st_q == RUN);

endmodule

// File: rtl/spd_slew.sv
// Wheel-speed slew limiter between the PID heading controller and the motor drive.
// Bounds per-tick speed change, ramps to zero when not moving, and dwells at zero before
// any direction reversal.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spd_slew_if slave (targets/moving in, slewed speeds/settled out)
module spd_slew #(
   parameter int unsigned STEP     = 8,
   parameter int unsigned TICK_DIV = 1024,
   parameter int unsigned DWELL    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   spd_slew_if.slave  bus
);
   import mtr_pkg::*;

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;
   spd_t          lft_spd, rght_spd;
   logic          run_l, run_r;
   logic          settled_q, settled_d;

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : PW'(pre_q + 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   spd_slew_chnl #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL)
   ) u_lft (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .moving (bus.moving),
      .tgt    (bus.tgt_lft),
      .spd    (lft_spd),
      .in_run (run_l)
   );

   spd_slew_chnl #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL)
   ) u_rght (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .moving (bus.moving),
      .tgt    (bus.tgt_rght),
      .spd    (rght_spd),
      .in_run (run_r)
   );

   // Evaluated every clk against the live inputs, not just on tick.
   always_comb begin
      settled_d = run_l && run_r &&
                  (lft_spd  == eff_tgt(bus.tgt_lft,  bus.moving)) &&
                  (rght_spd == eff_tgt(bus.tgt_rght, bus.moving));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settled_q <= 1'b0;
      end else begin
         settled_q <= settled_d;
      end
   end

   assign bus.lft_spd  = lft_spd;
   assign bus.rght_spd = rght_spd;
   assign bus.settled  = settled_q;

endmodule
